// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video source selector slice:
//   - state encoding of the selector FSM (RUN/PEND/SYNC/LOST)
//   - default 1280x720 timing constants
//   - RGB888 -> RGB565 packing helper
// No ports (package).
// ---------------------------------------------------------------------------
package video_pkg;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] SYNC = 2'd2;
  localparam logic [1:0] LOST = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = RUN,
    ST_PEND = PEND,
    ST_SYNC = SYNC,
    ST_LOST = LOST
  } mux_state_t;

  // Default 1280x720 raster
  localparam int H_ACTIVE = 1280;
  localparam int H_TOTAL  = 1650;
  localparam int V_ACTIVE = 720;
  localparam int V_TOTAL  = 750;

  // Keep the top bits of each 8-bit channel: R[7:3], G[7:2], B[7:3]
  function automatic logic [15:0] rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay
// Fixed-depth shift register for the {vs,hs,de} bundle so that sync can be
// aligned against a longer pixel pipeline downstream. DEPTH=0 degenerates to
// a plain wire.
// Ports:
//   clk    in   pixel clock
//   rst_n  in   asynchronous active-low reset (clears every stage)
//   d      in   WIDTH  bundle entering the delay line
//   q      out  WIDTH  bundle delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift register; stage[0] takes the new bundle, stage[DEPTH-1] is the output
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_src_mux.sv
// ---------------------------------------------------------------------------
// video_src_mux
// Frame-safe video source selector on the pixel clock. A source change is
// requested at any time but only takes effect on the current source's vsync
// rising edge; the first (partial) frame of the new source is blanked until
// its own vsync rises. Optional lost-source watchdog.
//
// Build option: define VIDEO_SRC_MUX_WATCHDOG_EN to include the watchdog
// counter, the LOST state and lost_o. Without it lost_o is tied to 0 and
// PEND/SYNC wait indefinitely.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   sel_i        in   SEL_W         requested source index
//   sel_req_i    in   1             request strobe, samples sel_i
//   src_vs_i     in   N_SRC         per-source vsync (positive)
//   src_hs_i     in   N_SRC         per-source hsync (positive)
//   src_de_i     in   N_SRC         per-source data enable
//   src_rgb_i    in   N_SRC*PIX_W   per-source pixel, source k at [k*PIX_W +: PIX_W]
//   vs_o/hs_o/de_o out 1            selected sync, 1+SYNC_DLY cycles latency
//   rgb_o        out  PIX_W         selected pixel, 1 cycle latency
//   rgb565_o     out  16            RGB565 packing of rgb_o
//   cur_sel_o    out  SEL_W         source driving the outputs
//   busy_o       out  1             switch pending or in progress
//   lost_o       out  1             watchdog tripped
//   frame_cnt_o  out  FCNT_W        frames delivered (wraps)
// ---------------------------------------------------------------------------
module video_src_mux
  import video_pkg::*;
#(
  parameter int N_SRC    = 3,
  parameter int PIX_W    = 24,
  parameter int SYNC_DLY = 4,
  parameter int TIMEOUT  = 2_000_000,
  parameter int FCNT_W   = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(N_SRC)-1:0]  sel_i,
  input  logic                      sel_req_i,
  input  logic [N_SRC-1:0]          src_vs_i,
  input  logic [N_SRC-1:0]          src_hs_i,
  input  logic [N_SRC-1:0]          src_de_i,
  input  logic [N_SRC*PIX_W-1:0]    src_rgb_i,
  output logic                      vs_o,
  output logic                      hs_o,
  output logic                      de_o,
  output logic [PIX_W-1:0]          rgb_o,
  output logic [15:0]               rgb565_o,
  output logic [$clog2(N_SRC)-1:0]  cur_sel_o,
  output logic                      busy_o,
  output logic                      lost_o,
  output logic [FCNT_W-1:0]         frame_cnt_o
);

  localparam int SEL_W = $clog2(N_SRC);
  localparam logic [SEL_W:0] N_SRC_L = (SEL_W+1)'(N_SRC);

  mux_state_t        state;
  mux_state_t        state_nxt;
  logic [SEL_W-1:0]  cur_sel;
  logic [SEL_W-1:0]  pend_sel;
  logic              pend_v;
  logic [N_SRC-1:0]  vs_q;
  logic [N_SRC-1:0]  vsr;
  logic              vsr_cur;
  logic              req_ok;
  logic              do_switch;
  logic              wd_trip;
  logic [FCNT_W-1:0] frame_cnt;
  logic              force_de;
  logic              force_all;
  logic              sel_vs;
  logic              sel_hs;
  logic              sel_de;
  logic [PIX_W-1:0]  sel_rgb;
  logic [PIX_W-1:0]  rgb_q;
  logic [2:0]        sync_q;
  logic [2:0]        sync_dly;

  // Previous vsync of every source; a rising edge is seen combinationally so
  // the FSM reacts in the cycle right after the edge is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= '0;
    end else begin
      vs_q <= src_vs_i;
    end
  end

  assign vsr     = src_vs_i & ~vs_q;
  assign vsr_cur = vsr[cur_sel];

  // Out-of-range indices are dropped; re-selecting the live source while
  // running is a no-op.
  assign req_ok    = sel_req_i && ({1'b0, sel_i} < N_SRC_L)
                     && !((state == ST_RUN) && (sel_i == cur_sel));
  assign do_switch = (state == ST_PEND) && vsr_cur;

`ifdef VIDEO_SRC_MUX_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  // Cycles since the selected source last started a frame, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (vsr_cur) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Trip as the count reaches TIMEOUT; a coincident vs edge wins
  assign wd_trip = (wd_cnt >= WD_LAST) && !vsr_cur;
`else
  assign wd_trip = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (wd_trip)     state_nxt = ST_LOST;
        else if (pend_v) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (vsr_cur)      state_nxt = ST_SYNC;
        else if (wd_trip) state_nxt = ST_LOST;
      end
      ST_SYNC: begin
        // vsr_cur already refers to the newly selected source here
        if (vsr_cur)      state_nxt = ST_RUN;
        else if (wd_trip) state_nxt = ST_LOST;
      end
      ST_LOST: begin
        if (vsr_cur) state_nxt = pend_v ? ST_PEND : ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs: status flags and the blanking forces on the data path
  always_comb begin
    busy_o    = (state == ST_PEND) || (state == ST_SYNC);
    force_de  = (state == ST_SYNC);
    force_all = (state == ST_LOST);
`ifdef VIDEO_SRC_MUX_WATCHDOG_EN
    lost_o    = (state == ST_LOST);
`else
    lost_o    = 1'b0;
`endif
  end

  // Pending request and current selection. A request arriving in the same
  // cycle as the transfer becomes the next pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel  <= '0;
      pend_sel <= '0;
      pend_v   <= 1'b0;
    end else begin
      if (do_switch) begin
        cur_sel <= pend_sel;
      end
      if (req_ok) begin
        pend_sel <= sel_i;
        pend_v   <= 1'b1;
      end else if (do_switch) begin
        pend_v   <= 1'b0;
      end
    end
  end

  // Frames delivered: only complete frames of a settled source count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if ((state == ST_RUN) && vsr_cur) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Source mux with blanking applied ahead of the output register
  always_comb begin
    sel_rgb = src_rgb_i[cur_sel*PIX_W +: PIX_W];
    sel_vs  = src_vs_i[cur_sel];
    sel_hs  = src_hs_i[cur_sel];
    sel_de  = src_de_i[cur_sel];
    if (force_all) begin
      sel_rgb = '0;
      sel_vs  = 1'b0;
      sel_hs  = 1'b0;
      sel_de  = 1'b0;
    end else if (force_de) begin
      sel_rgb = '0;
      sel_de  = 1'b0;
    end
  end

  // Common output register stage for pixel and sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      sync_q <= '0;
    end else begin
      rgb_q  <= sel_rgb;
      sync_q <= {sel_vs, sel_hs, sel_de};
    end
  end

  sync_delay #(
    .WIDTH (3),
    .DEPTH (SYNC_DLY)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sync_q),
    .q     (sync_dly)
  );

  assign {vs_o, hs_o, de_o} = sync_dly;
  assign rgb_o       = rgb_q;
  // Packing assumes 8 bits per channel in the low 24 bits
  assign rgb565_o    = rgb565(24'(rgb_q));
  assign cur_sel_o   = cur_sel;
  assign frame_cnt_o = frame_cnt;

endmodule

// File: doc/video_src_mux.md
# video_src_mux

Frame-safe, parametrised video source selector on the pixel clock. It sits between the video sources (test pattern, image-processing algorithm, renderer align stage) and the frame-buffer write port or DVI transmitter. It replaces the hard-wired source choice and fixed sync delay line with runtime selection that switches only at frame boundaries and blanks partial frames. It adds a per-path sync delay, RGB565 packing and a lost-source watchdog.

## Interface
Parameters:
- N_SRC, 3, number of video sources (2..8)
- PIX_W, 24, pixel width per source, {R,G,B} with 8 bits per channel at 24
- SYNC_DLY, 4, extra cycles applied to vs/hs/de relative to pixel data (0..15)
- TIMEOUT, 2_000_000, cycles without a selected-source vs rising edge before lost is declared
- FCNT_W, 9, frame counter width

Ports:
- clk  in  1  pixel clock (video_clk domain)
- rst_n  in  1  asynchronous, active-low reset
- sel_i  in  SEL_W=$clog2(N_SRC)  requested source index
- sel_req_i  in  1  one-cycle request strobe; sel_i is sampled with it
- src_vs_i  in  N_SRC  vsync per source, positive polarity
- src_hs_i  in  N_SRC  hsync per source, positive polarity
- src_de_i  in  N_SRC  data enable per source
- src_rgb_i  in  N_SRC*PIX_W  pixel data; source k occupies [k*PIX_W +: PIX_W]
- vs_o, hs_o, de_o  out  1  selected syncs, delayed
- rgb_o  out  PIX_W  selected pixel
- rgb565_o  out  16  {R[7:3],G[7:2],B[7:3]} of rgb_o
- cur_sel_o  out  SEL_W  source currently driving the outputs
- busy_o  out  1  switch pending or in progress
- lost_o  out  1  watchdog tripped
- frame_cnt_o  out  FCNT_W  frames delivered; wraps

## Operation
- Each source's vs is registered every cycle. vsr[k] marks a rising edge of source k.
- The FSM has four states: RUN, PEND, SYNC and LOST. The reset state is RUN with cur_sel = 0.
- sel_req_i handling:
  - Ignored if sel_i >= N_SRC.
  - Ignored in RUN if sel_i == cur_sel.
  - Otherwise sel_i is stored in the pending register and pend_v is set.
  - A later request overwrites the pending value.
- RUN with pend_v set moves to PEND.
- PEND, on vsr[cur_sel]: cur_sel <= pending, clear pend_v, move to SYNC.
- SYNC forces de and rgb to 0. vs and hs pass through from the new cur_sel.
  - On vsr[cur_sel], move to RUN.
  - If pend_v was set again in the meantime, RUN moves straight to PEND on the next cycle.
- Watchdog: a counter clears on vsr[cur_sel], otherwise increments and saturates.
  - Reaching TIMEOUT in any state moves the FSM to LOST and sets lost_o.
- LOST forces vs, hs, de and rgb to 0.
  - On vsr[cur_sel], clear lost_o and go to RUN if pend_v is clear, or PEND if it is set.
  - Requests are still accepted while in LOST.
- frame_cnt increments on vsr[cur_sel] while in RUN only, and wraps at 2^FCNT_W.
- busy_o = (state == PEND) || (state == SYNC).

## Timing
- Data path: one register stage on the muxed/forced rgb, so rgb_o lags src_rgb_i by 1 cycle.
- Sync path: the same register stage plus a SYNC_DLY-deep shift register, so vs_o/hs_o/de_o lag by 1+SYNC_DLY cycles. SYNC_DLY=0 gives equal latency.
- The mux select and blanking forces apply at the input of the first register stage.
  - A state change in cycle t therefore affects the outputs from cycle t+1 (data) and t+1+SYNC_DLY (sync).
- A state change takes effect in the cycle after the vs edge is registered, so the source's vs rise reaches the outputs through the normal latency.
- Reset values: all outputs 0, including the delay-line contents. cur_sel_o = 0, frame_cnt_o = 0, lost_o = 0, busy_o = 0.
- Reset asserted mid-switch abandons the pending request.
- Simultaneous events:
  - sel_req_i in the same cycle as the PEND-exit edge: the new request is stored after the transfer, so it is taken as the next pending value.
  - Watchdog trip and vs edge in the same cycle: the vs edge wins and the counter clears.

## Configuration
- VIDEO_SRC_MUX_WATCHDOG_EN:
  - Defined: watchdog counter, LOST state and lost_o logic as specified.
  - Undefined: no counter, LOST is unreachable and lost_o is tied to 0. PEND and SYNC wait indefinitely for the vs edge.

## Structure
- Shared package video_pkg holds:
  - the RGB565 packing function
  - state encoding localparams (RUN=2'd0, PEND=2'd1, SYNC=2'd2, LOST=2'd3)
  - the default timing constants for 1280x720 (h_total 1650, v_total 750)
- Sub-module sync_delay (parameters WIDTH, DEPTH) is the shift register for {vs,hs,de}. DEPTH=0 is a pass-through wire.

## Test plan
- Reset with rst_n low for 10 cycles, then release with N_SRC=3 and src 0 active at 1280x720 → rgb_o follows src 0 by 1 cycle, vs_o by 5 cycles, cur_sel_o=0, frame_cnt_o=1 after the first vs rise.
- sel_req_i with sel_i=2 mid-frame → busy_o=1. Outputs stay on src 0 until src 0's vs rises, then de_o=0 until src 2's vs rises, then de_o follows src 2. cur_sel_o=2, busy_o=0, frame_cnt_o unchanged during SYNC.
- sel_i=3 with N_SRC=3, and sel_i=0 while cur_sel=0 → no state change, busy_o stays 0.
- Two requests (1 then 2) inside one PEND → the switch lands on 2 only.
- With WATCHDOG_EN and TIMEOUT=1000, src 1 selected and vs held low → lost_o=1 after 1000 cycles with all outputs 0. The first vs rise restores RUN and clears lost_o.
- Reset asserted during SYNC → all outputs 0, cur_sel_o=0, pending cleared, and no switch after release.
